// File: rtl/ext_mem_ctrl.sv
// ---------------------------------------------------------------------------
// ext_mem_ctrl
//   Front end between a core and a single-port synchronous SRAM.
//   After a boot pulse it streams BOOT_PAD zero words (the first one tagged
//   with the acquire token), then the BOOT_LEN program words read from
//   SRAM addresses 0..BOOT_LEN-1. From then on it arbitrates core loads and
//   stores onto the SRAM port, one access per cycle, with round-robin on
//   conflicts and a hold register for load returns the core cannot accept.
//
// Ports
//   clock, reset          : clock, asynchronous active-low reset
//   I_Boot / O_Booting    : boot-start pulse / boot in progress
//   I_Ld_Req, I_Ld_Addr   : core load request
//   O_Ld_V, O_Ld_A, O_Ld_D: load-return valid, acquire token, data
//   I_Ld_Nack             : core back-pressure on the load return
//   I_St_Req, I_St_V,
//   I_St_Addr, I_St_D     : core store request, data valid, address, data
//   O_St_Nack             : store not accepted this cycle
//   O_Mem_*               : SRAM enable, write enable, address, write data
//   I_Mem_RData           : SRAM read data, one cycle after a read
// ---------------------------------------------------------------------------
module ext_mem_ctrl #(
  parameter int WIDTH_DATA   = 32,
  parameter int WIDTH_EXADDR = 12,
  parameter int BOOT_PAD     = 3,
  parameter int BOOT_LEN     = 5
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    I_Boot,
  output logic                    O_Booting,
  input  logic                    I_Ld_Req,
  input  logic [WIDTH_EXADDR-1:0] I_Ld_Addr,
  output logic                    O_Ld_V,
  output logic                    O_Ld_A,
  output logic [WIDTH_DATA-1:0]   O_Ld_D,
  input  logic                    I_Ld_Nack,
  input  logic                    I_St_Req,
  input  logic                    I_St_V,
  input  logic [WIDTH_EXADDR-1:0] I_St_Addr,
  input  logic [WIDTH_DATA-1:0]   I_St_D,
  output logic                    O_St_Nack,
  output logic                    O_Mem_En,
  output logic                    O_Mem_We,
  output logic [WIDTH_EXADDR-1:0] O_Mem_Addr,
  output logic [WIDTH_DATA-1:0]   O_Mem_WData,
  input  logic [WIDTH_DATA-1:0]   I_Mem_RData
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PAD    = 2'd1,
    S_BOOTRD = 2'd2,
    S_RUN    = 2'd3
  } state_t;

  localparam logic [2:0] PAD_LAST = 3'(BOOT_PAD - 1);
  localparam logic [2:0] LEN_LAST = 3'(BOOT_LEN - 1);

  state_t                  state_q, state_d;
  logic [2:0]              cnt_q, cnt_d;
  logic                    rd_ret_q, rd_ret_d;       // SRAM read data arrives this cycle
  logic                    boot_ret_q, boot_ret_d;   // ...and it is a boot word
  logic                    hold_pend_q, hold_pend_d; // a refused word sits in hold_q
  logic [WIDTH_DATA-1:0]   hold_q, hold_d;
  logic                    last_ld_q, last_ld_d;     // 1: last grant was a load

  logic                    ld_v_s;
  logic                    ld_a_s;
  logic [WIDTH_DATA-1:0]   ld_d_s;
  logic                    ld_cand_s;
  logic                    st_cand_s;
  logic                    ld_gnt_s;
  logic                    st_gnt_s;
  logic                    st_nack_s;
  logic                    mem_en_s;
  logic                    mem_we_s;
  logic [WIDTH_EXADDR-1:0] mem_addr_s;
  logic [WIDTH_DATA-1:0]   mem_wdata_s;

  // Word presented on the load-return port: pad word, held word or fresh SRAM data.
  always_comb begin
    ld_v_s = 1'b0;
    ld_a_s = 1'b0;
    ld_d_s = {WIDTH_DATA{1'b0}};
    if (state_q == S_PAD) begin
      ld_v_s = 1'b1;
      ld_a_s = (cnt_q == 3'd0);
    end else if (hold_pend_q) begin
      ld_v_s = 1'b1;
      ld_d_s = hold_q;
    end else if (rd_ret_q) begin
      ld_v_s = 1'b1;
      ld_d_s = I_Mem_RData;
    end else begin
      ld_v_s = 1'b0;
    end
  end

  // Run-mode arbitration between one load and one store candidate.
  // A load is also held off while the return of this cycle is being refused:
  // that word is about to move into the hold register, and a new read would
  // return on top of it.
  always_comb begin
    ld_cand_s = (state_q == S_RUN) && I_Ld_Req && !hold_pend_q && !boot_ret_q
                && !(rd_ret_q && I_Ld_Nack);
    st_cand_s = (state_q == S_RUN) && I_St_Req && I_St_V;
    if (ld_cand_s && st_cand_s) begin
      ld_gnt_s = !last_ld_q;
      st_gnt_s = last_ld_q;
    end else begin
      ld_gnt_s = ld_cand_s;
      st_gnt_s = st_cand_s;
    end
    st_nack_s = st_cand_s && !st_gnt_s;
  end

  // FSM next state, boot counter, SRAM command and hold-register update.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_ret_d    = 1'b0;
    boot_ret_d  = 1'b0;
    hold_pend_d = hold_pend_q;
    hold_d      = hold_q;
    last_ld_d   = last_ld_q;
    mem_en_s    = 1'b0;
    mem_we_s    = 1'b0;
    mem_addr_s  = {WIDTH_EXADDR{1'b0}};
    mem_wdata_s = {WIDTH_DATA{1'b0}};
    case (state_q)
      S_IDLE: begin
        if (I_Boot) begin
          state_d = S_PAD;
          cnt_d   = 3'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PAD: begin
        if (cnt_q == PAD_LAST) begin
          state_d = S_BOOTRD;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_BOOTRD: begin
        mem_en_s   = 1'b1;
        mem_addr_s = WIDTH_EXADDR'(cnt_q);
        rd_ret_d   = 1'b1;
        boot_ret_d = 1'b1;
        if (cnt_q == LEN_LAST) begin
          state_d = S_RUN;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_RUN: begin
        if (st_gnt_s) begin
          mem_en_s    = 1'b1;
          mem_we_s    = 1'b1;
          mem_addr_s  = I_St_Addr;
          mem_wdata_s = I_St_D;
          last_ld_d   = 1'b0;
        end else if (ld_gnt_s) begin
          mem_en_s   = 1'b1;
          mem_addr_s = I_Ld_Addr;
          rd_ret_d   = 1'b1;
          last_ld_d  = 1'b1;
        end else begin
          mem_en_s = 1'b0;
        end
        // Boot words ignore back-pressure; run-mode words are held while refused.
        if (ld_v_s && !boot_ret_q) begin
          hold_pend_d = I_Ld_Nack;
          if (I_Ld_Nack) begin
            hold_d = ld_d_s;
          end else begin
            hold_d = hold_q;
          end
        end else begin
          hold_pend_d = hold_pend_q;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // State registers; reset drops any in-flight or held word.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      rd_ret_q    <= 1'b0;
      boot_ret_q  <= 1'b0;
      hold_pend_q <= 1'b0;
      hold_q      <= {WIDTH_DATA{1'b0}};
      last_ld_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_ret_q    <= rd_ret_d;
      boot_ret_q  <= boot_ret_d;
      hold_pend_q <= hold_pend_d;
      hold_q      <= hold_d;
      last_ld_q   <= last_ld_d;
    end
  end

  assign O_Booting   = (state_q == S_PAD) || (state_q == S_BOOTRD);
  assign O_Ld_V      = ld_v_s;
  assign O_Ld_A      = ld_a_s;
  assign O_Ld_D      = ld_d_s;
  assign O_St_Nack   = st_nack_s;
  assign O_Mem_En    = mem_en_s;
  assign O_Mem_We    = mem_we_s;
  assign O_Mem_Addr  = mem_addr_s;
  assign O_Mem_WData = mem_wdata_s;

endmodule

// File: tb/tb_ext_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ext_mem_ctrl
//   Directed bench for ext_mem_ctrl with a behavioural SRAM, a transaction-
//   level reference model compared every cycle, and literal expectations for
//   the boot stream, load, conflict, back-pressure and reset scenarios.
// ---------------------------------------------------------------------------
module tb_ext_mem_ctrl;

  localparam int WD = 32;
  localparam int WA = 12;
  localparam int NP = 3;
  localparam int NL = 5;

  logic          clock = 1'b0;
  logic          reset;
  logic          I_Boot, I_Ld_Req, I_Ld_Nack, I_St_Req, I_St_V;
  logic [WA-1:0] I_Ld_Addr, I_St_Addr;
  logic [WD-1:0] I_St_D;
  logic          O_Booting, O_Ld_V, O_Ld_A, O_St_Nack, O_Mem_En, O_Mem_We;
  logic [WD-1:0] O_Ld_D, O_Mem_WData;
  logic [WA-1:0] O_Mem_Addr;
  logic [WD-1:0] mem_rdata;

  // Preload port into both the SRAM and the model's memory image.
  logic          pre_en;
  logic [WA-1:0] pre_a;
  logic [WD-1:0] pre_d;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  ext_mem_ctrl #(.WIDTH_DATA(WD), .WIDTH_EXADDR(WA), .BOOT_PAD(NP), .BOOT_LEN(NL)) dut (
    .clock(clock), .reset(reset), .I_Boot(I_Boot), .O_Booting(O_Booting),
    .I_Ld_Req(I_Ld_Req), .I_Ld_Addr(I_Ld_Addr), .O_Ld_V(O_Ld_V), .O_Ld_A(O_Ld_A),
    .O_Ld_D(O_Ld_D), .I_Ld_Nack(I_Ld_Nack), .I_St_Req(I_St_Req), .I_St_V(I_St_V),
    .I_St_Addr(I_St_Addr), .I_St_D(I_St_D), .O_St_Nack(O_St_Nack),
    .O_Mem_En(O_Mem_En), .O_Mem_We(O_Mem_We), .O_Mem_Addr(O_Mem_Addr),
    .O_Mem_WData(O_Mem_WData), .I_Mem_RData(mem_rdata)
  );

  // Synchronous single-port SRAM.
  logic [WD-1:0] env_mem [0:(1<<WA)-1];
  always @(posedge clock) begin
    if (pre_en) env_mem[pre_a] <= pre_d;
    else if (O_Mem_En && O_Mem_We) env_mem[O_Mem_Addr] <= O_Mem_WData;
    else if (O_Mem_En) mem_rdata <= env_mem[O_Mem_Addr];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Boot is a cycle index into the fixed pad/read schedule; run mode keeps the
  // memory image, the word arriving next cycle, the held word and who won last.
  logic [WD-1:0] ref_mem [0:(1<<WA)-1];
  int            m_step = -1;      // -1: not booting, else cycle index within boot
  bit            m_run = 1'b0;
  bit            m_last_boot = 1'b0;
  bit            m_ret_v = 1'b0;
  logic [WD-1:0] m_ret_d;
  bit            m_hold_v = 1'b0;
  logic [WD-1:0] m_hold_d;
  bit            m_last_load = 1'b0;

  always @(negedge clock) begin
    bit            e_bt, e_v, e_a, e_en, e_we, e_nack, ld_c, st_c, g_ld, g_st;
    logic [WD-1:0] e_d, e_wd;
    logic [WA-1:0] e_ad;
    int            k;
    if (pre_en) ref_mem[pre_a] = pre_d;
    e_bt = 0; e_v = 0; e_a = 0; e_en = 0; e_we = 0; e_nack = 0;
    e_d = '0; e_wd = '0; e_ad = '0; g_ld = 0; g_st = 0;
    if (!reset) begin
      m_step = -1; m_run = 0; m_last_boot = 0; m_ret_v = 0; m_hold_v = 0; m_last_load = 0;
    end else if (m_step >= 0) begin
      e_bt = 1;
      if (m_step < NP) begin
        e_v = 1; e_a = (m_step == 0);
      end else begin
        k = m_step - NP;
        e_en = 1; e_ad = WA'(k);
        if (k > 0) begin e_v = 1; e_d = ref_mem[k-1]; end
      end
    end else if (m_run) begin
      if (m_last_boot) begin e_v = 1; e_d = ref_mem[NL-1]; end
      else if (m_hold_v) begin e_v = 1; e_d = m_hold_d; end
      else if (m_ret_v) begin e_v = 1; e_d = m_ret_d; end
      ld_c = I_Ld_Req && !m_hold_v && !m_last_boot && !(m_ret_v && I_Ld_Nack);
      st_c = I_St_Req && I_St_V;
      g_ld = ld_c && (!st_c || !m_last_load);
      g_st = st_c && !g_ld;
      e_nack = st_c && !g_st;
      if (g_st) begin e_en = 1; e_we = 1; e_ad = I_St_Addr; e_wd = I_St_D; end
      if (g_ld) begin e_en = 1; e_ad = I_Ld_Addr; end
    end
    chk("m_booting", O_Booting, e_bt);
    chk("m_ld_v", O_Ld_V, e_v);
    chk("m_ld_a", O_Ld_A, e_a);
    chk("m_ld_d", O_Ld_D, e_d);
    chk("m_st_nack", O_St_Nack, e_nack);
    chk("m_mem_en", O_Mem_En, e_en);
    chk("m_mem_we", O_Mem_We, e_we);
    if (e_en) chk("m_mem_addr", O_Mem_Addr, e_ad);
    if (e_we) chk("m_mem_wdata", O_Mem_WData, e_wd);
    // advance the model to the next cycle (inputs are stable until the next edge)
    if (!reset) begin
      m_step = -1;
    end else if (m_step >= 0) begin
      m_step++;
      if (m_step == NP + NL) begin m_step = -1; m_run = 1; m_last_boot = 1; end
    end else if (m_run) begin
      if (e_v && !m_last_boot) begin
        m_hold_v = I_Ld_Nack;
        if (I_Ld_Nack) m_hold_d = e_d;
      end
      m_last_boot = 0;
      m_ret_v = g_ld;
      if (g_ld) m_ret_d = ref_mem[I_Ld_Addr];
      if (g_st) ref_mem[I_St_Addr] = I_St_D;
      if (g_ld || g_st) m_last_load = g_ld;
    end else if (I_Boot) begin
      m_step = 0;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic next();
    @(posedge clock); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic          s_v [0:9];
    logic          s_a [0:9];
    logic          s_bt[0:9];
    logic [WD-1:0] s_d [0:9];
    reset = 1'b0; I_Boot = 1'b0; I_Ld_Req = 1'b0; I_Ld_Nack = 1'b0; I_St_Req = 1'b0;
    I_St_V = 1'b0; I_Ld_Addr = '0; I_St_Addr = '0; I_St_D = '0;
    pre_en = 1'b0; pre_a = '0; pre_d = '0;
    next();
    // preload SRAM[0..4]=0x11..0x55 and SRAM[0x100]=0xDEADBEEF
    for (int i = 0; i < 6; i++) begin
      pre_en = 1'b1;
      pre_a  = (i < 5) ? WA'(i) : 12'h100;
      pre_d  = (i < 5) ? 32'(32'h11 * (i + 1)) : 32'hDEADBEEF;
      next();
    end
    pre_en = 1'b0;
    @(negedge clock);
    chk("rst_ld_v", O_Ld_V, 0);
    chk("rst_mem_en", O_Mem_En, 0);
    chk("rst_booting", O_Booting, 0);
    next();
    reset = 1'b1;
    next(); next();

    // boot stream
    I_Boot = 1'b1; next(); I_Boot = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      s_v[i] = O_Ld_V; s_a[i] = O_Ld_A; s_d[i] = O_Ld_D; s_bt[i] = O_Booting;
      next();
    end
    chk("boot_pad0", {s_v[0], s_a[0], s_bt[0]}, 3'b111);
    chk("boot_pad0_d", s_d[0], 0);
    chk("boot_pad1", {s_v[1], s_a[1], s_d[1]}, {2'b10, 32'h0});
    chk("boot_pad2", {s_v[2], s_a[2], s_d[2]}, {2'b10, 32'h0});
    chk("boot_gap", {s_v[3], s_bt[3]}, 2'b01);
    for (int i = 4; i < 9; i++) chk("boot_word", {s_v[i], s_a[i], s_d[i]}, {2'b10, 32'(32'h11 * (i - 3))});
    chk("boot_done_bt", {s_bt[8], s_bt[9]}, 2'b00);
    chk("boot_after_v", s_v[9], 0);

    // I_Boot is ignored in run mode
    I_Boot = 1'b1; next(); I_Boot = 1'b0;
    @(negedge clock); chk("boot_ignored", O_Booting, 0); next();

    // plain load
    I_Ld_Req = 1'b1; I_Ld_Addr = 12'h100; next(); I_Ld_Req = 1'b0;
    @(negedge clock); chk("load_ret", {O_Ld_V, O_Ld_A, O_Ld_D}, {2'b10, 32'hDEADBEEF}); next();

    // store then load
    I_St_Req = 1'b1; I_St_V = 1'b1; I_St_Addr = 12'h300; I_St_D = 32'h12345678; next();
    I_St_Req = 1'b0; I_St_V = 1'b0;
    I_Ld_Req = 1'b1; I_Ld_Addr = 12'h300; next(); I_Ld_Req = 1'b0;
    @(negedge clock); chk("st_then_ld", O_Ld_D, 32'h12345678); next();

    // lone store so the last grant is a store, then 4 conflicting cycles
    I_St_Req = 1'b1; I_St_V = 1'b1; I_St_Addr = 12'h310; I_St_D = 32'hA; next();
    for (int i = 0; i < 4; i++) begin
      I_Ld_Req = 1'b1; I_Ld_Addr = 12'h300;
      I_St_Req = 1'b1; I_St_V = 1'b1; I_St_Addr = WA'(12'h320 + i); I_St_D = 32'(i);
      @(negedge clock);
      chk("conflict_ld_grant", O_Mem_En && !O_Mem_We, (i % 2) == 0);
      chk("conflict_nack", O_St_Nack, (i % 2) == 0);
      next();
    end
    I_Ld_Req = 1'b0; I_St_Req = 1'b0; I_St_V = 1'b0;
    next();

    // back-pressure with a concurrent store
    I_Ld_Req = 1'b1; I_Ld_Addr = 12'h100; next();
    I_Ld_Addr = 12'h300; I_Ld_Nack = 1'b1;
    I_St_Req = 1'b1; I_St_V = 1'b1; I_St_Addr = 12'h200; I_St_D = 32'h5A5A5A5A;
    @(negedge clock);
    chk("bp_hold0", {O_Ld_V, O_Ld_D}, {1'b1, 32'hDEADBEEF});
    chk("bp_store", {O_Mem_En, O_Mem_We, O_Mem_WData}, {2'b11, 32'h5A5A5A5A});
    next();
    I_St_Req = 1'b0; I_St_V = 1'b0;
    @(negedge clock); chk("bp_hold1", {O_Ld_V, O_Ld_D}, {1'b1, 32'hDEADBEEF}); next();
    @(negedge clock); chk("bp_hold2", {O_Ld_V, O_Ld_D}, {1'b1, 32'hDEADBEEF}); next();
    I_Ld_Nack = 1'b0; I_Ld_Req = 1'b0;
    @(negedge clock); chk("bp_hold3", {O_Ld_V, O_Ld_D}, {1'b1, 32'hDEADBEEF}); next();
    @(negedge clock); chk("bp_release", O_Ld_V, 0); next();
    I_Ld_Req = 1'b1; I_Ld_Addr = 12'h200; next(); I_Ld_Req = 1'b0;
    @(negedge clock); chk("bp_store_data", O_Ld_D, 32'h5A5A5A5A); next();

    // reset in the middle of the boot reads
    reset = 1'b0; next(); next(); reset = 1'b1; next();
    I_Boot = 1'b1; next(); I_Boot = 1'b0;
    next(); next(); next(); next();
    @(negedge clock); chk("midboot_pre_v", {O_Booting, O_Ld_V}, 2'b11);
    next();
    reset = 1'b0;
    @(negedge clock);
    chk("midboot_rst_out", {O_Booting, O_Ld_V, O_Ld_A, O_St_Nack, O_Mem_En, O_Mem_We}, 6'b0);
    chk("midboot_rst_d", O_Ld_D, 0);
    next();
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock); chk("midboot_no_restart", {O_Booting, O_Ld_V}, 2'b00); next();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
